// File: rtl/yarp_pkg.sv
// Shared types and constants for the YARP data-memory path.
// Holds the access-size encoding, the bus-bridge FSM states and the misalignment rule.
package yarp_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned NUM_LANES = XLEN / LANE_W;
    localparam int unsigned OFF_W     = 2;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_access_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10,
        DONE = 2'b11
    } dmem_bridge_state_e;

    // The unused size code 2'b10 falls into the WORD rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
        case (size)
            BYTE:      return 1'b0;
            HALF_WORD: return off[0];
            default:   return off != '0;
        endcase
    endfunction

endpackage

// File: rtl/yarp_dmem_lane_align.sv
// Byte-lane steering for the data-memory bridge: strobes and write-data replication
// from size/offset, plus right-justification of returned read data.
module yarp_dmem_lane_align
    import yarp_pkg::*;
(
    input  logic [1:0]           size,
    input  logic [OFF_W-1:0]     off,
    input  logic [XLEN-1:0]      wr_data,
    input  logic [XLEN-1:0]      bus_rdata,
    output logic [NUM_LANES-1:0] strb,
    output logic [XLEN-1:0]      bus_wdata,
    output logic [XLEN-1:0]      rd_data
);

    // Strobes shifted past lane 3 are dropped by the 4-bit result width.
    always_comb begin
        strb      = 4'b1111;
        bus_wdata = wr_data;
        case (size)
            BYTE: begin
                strb      = 4'b0001 << off;
                bus_wdata = {4{wr_data[7:0]}};
            end
            HALF_WORD: begin
                strb      = 4'b0011 << off;
                bus_wdata = {2{wr_data[15:0]}};
            end
            default: begin
                strb      = 4'b1111;
                bus_wdata = wr_data;
            end
        endcase
    end

    assign rd_data = bus_rdata >> {off, 3'b000};

endmodule

// File: rtl/yarp_dmem_bus_bridge.sv
// Single-beat core data access to word-aligned req/gnt + rvalid bus bridge with timeout.
// Optional misalignment trap enabled by defining YARP_DMEM_MISALIGN_CHK_EN.
//
// state | meaning
// IDLE  | waiting for req_i; access fields captured on request
// REQ   | bus_req_o high, bus fields stable, waiting for bus_gnt_i
// RSP   | request accepted, waiting for bus_rvalid_i
// DONE  | one cycle, results visible, stall_o low
module yarp_dmem_bus_bridge
    import yarp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TMO_W          = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_i,
    input  logic [XLEN-1:0]      addr_i,
    input  logic [1:0]           byte_en_i,
    input  logic                 wr_i,
    input  logic [XLEN-1:0]      wr_data_i,
    output logic [XLEN-1:0]      rd_data_o,
    output logic                 stall_o,
    output logic                 err_o,
`ifdef YARP_DMEM_MISALIGN_CHK_EN
    output logic                 misaligned_o,
`endif
    output logic                 bus_req_o,
    output logic [XLEN-1:0]      bus_addr_o,
    output logic                 bus_we_o,
    output logic [NUM_LANES-1:0] bus_strb_o,
    output logic [XLEN-1:0]      bus_wdata_o,
    input  logic                 bus_gnt_i,
    input  logic                 bus_rvalid_i,
    input  logic [XLEN-1:0]      bus_rdata_i,
    input  logic                 bus_err_i
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    dmem_bridge_state_e state_q, state_d;

    logic [XLEN-1:0]      addr_q;
    logic [1:0]           size_q;
    logic                 wr_q;
    logic [XLEN-1:0]      wdata_q;
    logic [XLEN-1:0]      rd_data_q;
    logic                 err_q;
    logic [TMO_W-1:0]     tmo_cnt_q;

    logic                 tmo_hit;
    logic                 misaligned_req;
    logic                 in_req;
    logic                 in_done;
    logic [NUM_LANES-1:0] lane_strb;
    logic [XLEN-1:0]      lane_wdata;
    logic [XLEN-1:0]      lane_rdata;

    yarp_dmem_lane_align u_lane_align (
        .size      (size_q),
        .off       (addr_q[OFF_W-1:0]),
        .wr_data   (wdata_q),
        .bus_rdata (bus_rdata_i),
        .strb      (lane_strb),
        .bus_wdata (lane_wdata),
        .rd_data   (lane_rdata)
    );

`ifdef YARP_DMEM_MISALIGN_CHK_EN
    logic mis_q;
    assign misaligned_req = is_misaligned(byte_en_i, addr_i[OFF_W-1:0]);
`else
    assign misaligned_req = 1'b0;
`endif

    // Count covers REQ and RSP together; counter starts at 0 on the first REQ cycle.
    assign tmo_hit = (tmo_cnt_q >= TMO_LAST);
    assign in_req  = (state_q == REQ);
    assign in_done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = misaligned_req ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus_gnt_i) begin
                    state_d = RSP;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            RSP: begin
                if (bus_rvalid_i || tmo_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            tmo_cnt_q <= '0;
`ifdef YARP_DMEM_MISALIGN_CHK_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        addr_q    <= addr_i;
                        size_q    <= byte_en_i;
                        wr_q      <= wr_i;
                        wdata_q   <= wr_data_i;
                        rd_data_q <= '0;
                        err_q     <= 1'b0;
                        tmo_cnt_q <= '0;
`ifdef YARP_DMEM_MISALIGN_CHK_EN
                        mis_q     <= misaligned_req;
`endif
                    end
                end
                REQ: begin
                    tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    if (!bus_gnt_i && tmo_hit) begin
                        err_q <= 1'b1;
                    end
                end
                RSP: begin
                    tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    if (bus_rvalid_i) begin
                        if (bus_err_i) begin
                            err_q <= 1'b1;
                        end else if (!wr_q) begin
                            rd_data_q <= lane_rdata;
                        end
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus fields are only driven while the request is outstanding.
    assign bus_req_o   = in_req;
    assign bus_addr_o  = in_req ? {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus_we_o    = in_req & wr_q;
    assign bus_strb_o  = in_req ? lane_strb : '0;
    assign bus_wdata_o = in_req ? lane_wdata : '0;

    assign rd_data_o = in_done ? rd_data_q : '0;
    assign err_o     = in_done & err_q;
    assign stall_o   = reset_n && !in_done && (req_i || (state_q != IDLE));

`ifdef YARP_DMEM_MISALIGN_CHK_EN
    assign misaligned_o = in_done & mis_q;
`endif

endmodule

// File: tb/tb_yarp_dmem_bus_bridge.sv
// Self-checking bench for yarp_dmem_bus_bridge: directed vector table, reset and
// timeout sequences, and randomized accesses against a transaction-level model.
module tb_yarp_dmem_bus_bridge;
    import yarp_pkg::*;

    localparam int TMO    = 255;
    localparam int NO_GNT = 1000;

    logic        clk;
    logic        reset_n;
    logic        req_i;
    logic [31:0] addr_i;
    logic [1:0]  byte_en_i;
    logic        wr_i;
    logic [31:0] wr_data_i;
    logic [31:0] rd_data_o;
    logic        stall_o;
    logic        err_o;
`ifdef YARP_DMEM_MISALIGN_CHK_EN
    logic        misaligned_o;
`endif
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_we_o;
    logic [3:0]  bus_strb_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;

    int n_cmp = 0;
    int n_bad = 0;

    yarp_dmem_bus_bridge #(.TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .byte_en_i    (byte_en_i),
        .wr_i         (wr_i),
        .wr_data_i    (wr_data_i),
        .rd_data_o    (rd_data_o),
        .stall_o      (stall_o),
        .err_o        (err_o),
`ifdef YARP_DMEM_MISALIGN_CHK_EN
        .misaligned_o (misaligned_o),
`endif
        .bus_req_o    (bus_req_o),
        .bus_addr_o   (bus_addr_o),
        .bus_we_o     (bus_we_o),
        .bus_strb_o   (bus_strb_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_i    (bus_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  sz;
        logic        wr;
        logic [31:0] wdata;
        int          g;
        int          r;
        logic [31:0] rdata;
        logic        berr;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
        logic        e_err;
        int          e_done;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lanes_of(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] a, input logic [1:0] s);
        int n;
        int m;
        n = lanes_of(s);
        if (n == 4) return 4'hF;
        m = ((1 << n) - 1) << a[1:0];
        return 4'(m & 15);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] s);
        logic [31:0] o;
        int n;
        n = lanes_of(s);
        o = '0;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = d[8*(i % n) +: 8];
        return o;
    endfunction

    function automatic logic model_mis(input logic [31:0] a, input logic [1:0] s);
`ifdef YARP_DMEM_MISALIGN_CHK_EN
        int n;
        n = lanes_of(s);
        if (n == 2) return a[0];
        if (n == 4) return a[1:0] != 2'b00;
        return 1'b0;
`else
        return (a[0] & 1'b0) | (s[0] & 1'b0);
`endif
    endfunction

    // Drives one access cycle by cycle; cycle 0 is the IDLE cycle carrying req_i.
    task automatic run_txn(input string nm, input logic [31:0] a, input logic [1:0] sz,
                           input logic w, input logic [31:0] d, input int g, input int r,
                           input logic [31:0] rdat, input logic be,
                           input logic [31:0] e_addr, input logic [3:0] e_strb,
                           input logic [31:0] e_wdata, input logic [31:0] e_rd,
                           input logic e_err, input logic e_mis, input int e_done);
        int reqcyc;
        int rvcyc;
        logic in_req;
        reqcyc = e_mis ? 0 : ((g <= TMO - 1) ? g + 1 : TMO);
        rvcyc  = (g <= TMO - 1) ? g + 2 + r : -1;
        for (int c = 0; c <= e_done; c++) begin
            @(posedge clk); #1;
            req_i     = 1'b1;
            addr_i    = a;
            byte_en_i = sz;
            wr_i      = w;
            wr_data_i = d;
            bus_gnt_i = (c == 1 + g);
            in_req    = (c >= 1) && (c <= reqcyc);
            if (c == rvcyc) begin
                bus_rvalid_i = 1'b1;
                bus_rdata_i  = rdat;
                bus_err_i    = be;
            end else if (in_req) begin
                bus_rvalid_i = 1'($urandom_range(0, 1));
                bus_rdata_i  = $urandom;
                bus_err_i    = 1'($urandom_range(0, 1));
            end else begin
                bus_rvalid_i = 1'b0;
                bus_rdata_i  = $urandom;
                bus_err_i    = 1'b0;
            end
            @(negedge clk);
            chk({nm, ".stall"}, 32'(stall_o), 32'(c != e_done));
            chk({nm, ".bus_req"}, 32'(bus_req_o), 32'(in_req));
            if (in_req) begin
                chk({nm, ".bus_addr"}, bus_addr_o, e_addr);
                chk({nm, ".strb"}, 32'(bus_strb_o), 32'(e_strb));
                chk({nm, ".wdata"}, bus_wdata_o, e_wdata);
                chk({nm, ".we"}, 32'(bus_we_o), 32'(w));
            end
            chk({nm, ".rd_data"}, rd_data_o, (c == e_done) ? e_rd : 32'h0);
            chk({nm, ".err"}, 32'(err_o), (c == e_done) ? 32'(e_err) : 32'h0);
`ifdef YARP_DMEM_MISALIGN_CHK_EN
            chk({nm, ".misaligned"}, 32'(misaligned_o), (c == e_done) ? 32'(e_mis) : 32'h0);
`endif
        end
    endtask

    task automatic run_model(input string nm, input logic [31:0] a, input logic [1:0] sz,
                             input logic w, input logic [31:0] d, input int g, input int r,
                             input logic [31:0] rdat, input logic be);
        logic mis;
        logic acc;
        logic err;
        int done;
        int allowed;
        logic [31:0] rd;
        mis = model_mis(a, sz);
        if (mis) begin
            done = 1;
            err  = 1'b0;
        end else if (g > TMO - 1) begin
            done = 1 + TMO;
            err  = 1'b1;
        end else begin
            allowed = (g + 1 <= TMO - 1) ? (TMO - 1) - (g + 1) : 0;
            acc  = (r <= allowed);
            done = 1 + (g + 1) + (acc ? r + 1 : allowed + 1);
            err  = !acc || be;
        end
        rd = (mis || err || w) ? 32'h0 : (rdat >> (8 * int'(a[1:0])));
        run_txn(nm, a, sz, w, d, g, r, rdat, be, {a[31:2], 2'b00}, model_strb(a, sz),
                model_wdata(d, sz), rd, err, mis, done);
    endtask

    // Idle cycles with stray bus responses that must not start anything.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_i        = 1'b0;
            bus_gnt_i    = 1'b1;
            bus_rvalid_i = 1'b1;
            bus_err_i    = 1'b1;
            bus_rdata_i  = $urandom;
            @(negedge clk);
            chk("idle.stall", 32'(stall_o), 32'h0);
            chk("idle.bus_req", 32'(bus_req_o), 32'h0);
            chk("idle.err", 32'(err_o), 32'h0);
            chk("idle.rd_data", rd_data_o, 32'h0);
        end
        @(posedge clk); #1;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_err_i    = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".stall"}, 32'(stall_o), 32'h0);
        chk({nm, ".bus_req"}, 32'(bus_req_o), 32'h0);
        chk({nm, ".rd_data"}, rd_data_o, 32'h0);
        chk({nm, ".err"}, 32'(err_o), 32'h0);
        chk({nm, ".bus_addr"}, bus_addr_o, 32'h0);
        chk({nm, ".strb"}, 32'(bus_strb_o), 32'h0);
        chk({nm, ".wdata"}, bus_wdata_o, 32'h0);
        chk({nm, ".we"}, 32'(bus_we_o), 32'h0);
    endtask

    initial begin
        vecs[0] = '{32'h100, 2'b11, 1'b0, 32'h12345678, 0, 0, 32'hDEADBEEF, 1'b0,
                    32'h100, 4'hF, 32'h12345678, 32'hDEADBEEF, 1'b0, 3};
        vecs[1] = '{32'h203, 2'b00, 1'b1, 32'h000000A5, 0, 0, 32'h11223344, 1'b0,
                    32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0, 3};
        vecs[2] = '{32'h42, 2'b01, 1'b0, 32'h0, 0, 0, 32'h80017FFF, 1'b0,
                    32'h40, 4'b1100, 32'h0, 32'h00008001, 1'b0, 3};
        vecs[3] = '{32'h1000, 2'b11, 1'b1, 32'hCAFEF00D, 5, 2, 32'h0, 1'b0,
                    32'h1000, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 10};
        vecs[4] = '{32'h8, 2'b11, 1'b0, 32'h0, 1, 1, 32'hFFFFFFFF, 1'b1,
                    32'h8, 4'hF, 32'h0, 32'h0, 1'b1, 5};
        vecs[5] = '{32'h300, 2'b10, 1'b0, 32'h55AA55AA, 0, 3, 32'h01020304, 1'b0,
                    32'h300, 4'hF, 32'h55AA55AA, 32'h01020304, 1'b0, 6};
        vecs[6] = '{32'h1, 2'b00, 1'b0, 32'h000000FF, 0, 0, 32'hAABBCCDD, 1'b0,
                    32'h0, 4'b0010, 32'hFFFFFFFF, 32'h00AABBCC, 1'b0, 3};
        vecs[7] = '{32'h2, 2'b01, 1'b1, 32'hBEEF1234, 2, 0, 32'h0, 1'b0,
                    32'h0, 4'b1100, 32'h12341234, 32'h0, 1'b0, 5};
        vecs[8] = '{32'h500, 2'b11, 1'b0, 32'h0, NO_GNT, 0, 32'h0, 1'b0,
                    32'h500, 4'hF, 32'h0, 32'h0, 1'b1, 1 + TMO};

        reset_n      = 1'b0;
        req_i        = 1'b1;
        addr_i       = 32'h0;
        byte_en_i    = 2'b11;
        wr_i         = 1'b0;
        wr_data_i    = 32'h0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'h0;
        bus_err_i    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        req_i   = 1'b0;
        @(negedge clk);
        chk("post_reset.stall", 32'(stall_o), 32'h0);

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].sz, vecs[i].wr, vecs[i].wdata,
                    vecs[i].g, vecs[i].r, vecs[i].rdata, vecs[i].berr, vecs[i].e_addr,
                    vecs[i].e_strb, vecs[i].e_wdata, vecs[i].e_rd, vecs[i].e_err, 1'b0,
                    vecs[i].e_done);
        end
        idle_cycles(2);

        // Reset while the bridge waits for the response.
        @(posedge clk); #1;
        req_i = 1'b1; addr_i = 32'h700; byte_en_i = 2'b11; wr_i = 1'b1; wr_data_i = 32'h13579BDF;
        @(negedge clk);
        chk("rst_mid.idle_stall", 32'(stall_o), 32'h1);
        @(posedge clk); #1;
        bus_gnt_i = 1'b1;
        @(negedge clk);
        chk("rst_mid.bus_req", 32'(bus_req_o), 32'h1);
        @(posedge clk); #1;
        bus_gnt_i = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_mid");
        @(posedge clk); #1;
        reset_n      = 1'b1;
        req_i        = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_gnt_i    = 1'b1;
        @(negedge clk);
        chk("rst_mid.late_stall", 32'(stall_o), 32'h0);
        chk("rst_mid.late_req", 32'(bus_req_o), 32'h0);
        chk("rst_mid.late_rd", rd_data_o, 32'h0);
        run_txn("after_rst", vecs[0].addr, vecs[0].sz, vecs[0].wr, vecs[0].wdata, 0, 0,
                vecs[0].rdata, 1'b0, vecs[0].e_addr, vecs[0].e_strb, vecs[0].e_wdata,
                vecs[0].e_rd, 1'b0, 1'b0, 3);

        // Misaligned WORD: trapped with the macro, issued with word strobes without it.
        run_model("mis_word", 32'h101, 2'b11, 1'b0, 32'h0, 0, 0, 32'h44332211, 1'b0);
        run_model("mis_half", 32'h203, 2'b01, 1'b1, 32'h0000ABCD, 1, 0, 32'h0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            run_model($sformatf("rnd%0d", i), $urandom, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 2) == 0) idle_cycles(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
